// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM geometry, sprite slot layout and the mode-2 scan state enum.
package ppu_pkg;

    localparam int MAX_SPRITES = 10;
    localparam int OAM_ENTRIES = 40;
    localparam int OAM_BYTES   = OAM_ENTRIES * 4;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    localparam int SLOT_W        = 48;
    localparam int SLOT_VALID    = 47;
    localparam int SLOT_IDX_LSB  = 40;
    localparam int SLOT_ROW_LSB  = 32;
    localparam int SLOT_Y_LSB    = 24;
    localparam int SLOT_X_LSB    = 16;
    localparam int SLOT_TILE_LSB = 8;
    localparam int SLOT_FLAG_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SLOT_W-1:0] make_slot(
        input logic [5:0] idx,
        input logic [7:0] row,
        input logic [7:0] y,
        input logic [7:0] x,
        input logic [7:0] tile,
        input logic [7:0] flags
    );
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_VALID]              = 1'b1;
        s[SLOT_IDX_LSB  +: 6]      = idx;
        s[SLOT_ROW_LSB  +: 8]      = row;
        s[SLOT_Y_LSB    +: 8]      = y;
        s[SLOT_X_LSB    +: 8]      = x;
        s[SLOT_TILE_LSB +: 8]      = tile;
        s[SLOT_FLAG_LSB +: 8]      = flags;
        return s;
    endfunction

endpackage

// File: rtl/sprite_match.sv
// Combinational test of whether a sprite's Y range covers the current line, plus the row within it.
module sprite_match (
    input  logic [7:0] ly,
    input  logic [7:0] y,
    input  logic       tall,
    output logic       hit,
    output logic [7:0] row
);

    logic [8:0] line9;
    logic [8:0] top9;
    logic [8:0] bot9;

    // 9-bit so Y near 255 plus height cannot wrap into a false match
    assign line9 = {1'b0, ly} + 9'd16;
    assign top9  = {1'b0, y};
    assign bot9  = top9 + (tall ? 9'd16 : 9'd8);
    assign hit   = (line9 >= top9) && (line9 < bot9);
    assign row   = ly + 8'd16 - y;

endmodule

// File: rtl/mode_2_fsm.sv
// OAM scan: walks all 160 OAM bytes for one line and queues up to MAX_SPRITES sprites covering it.
module mode_2_fsm
    import ppu_pkg::*;
#(
    parameter int MAX_SPRITES = ppu_pkg::MAX_SPRITES,
    parameter int OAM_ENTRIES = ppu_pkg::OAM_ENTRIES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [7:0]                         LCDC,
    input  logic [7:0]                         LY,
    input  logic [7:0]                         oam_dout,
    output logic                               done_out,
    output logic                               busy,
    output logic [15:0]                        oam_a,
    output logic [MAX_SPRITES-1:0][SLOT_W-1:0] sprite_queue,
    output logic [3:0]                         sprite_count,
    output state_t                             state_dbg
);

    // Handshake: start is a one-cycle request accepted in any state (restarting any scan in flight);
    // done_out is a one-cycle completion pulse, after which the queue is held until the next start.

    localparam int SCAN_BYTES = OAM_ENTRIES * 4;
    localparam logic [7:0] LAST_CNT = 8'(SCAN_BYTES + 1);

    state_t state_r, state_nx;

    logic [7:0]  cnt_r;
    logic [7:0]  ly_r;
    logic        tall_r;
    logic        en_r;
    logic [7:0]  y_r;
    logic [7:0]  x_r;
    logic [7:0]  tile_r;
    logic [MAX_SPRITES-1:0][SLOT_W-1:0] queue_r;
    logic [3:0]  count_r;

    logic        hit;
    logic [7:0]  row;
    logic [7:0]  byte_idx;
    logic        capture_en;
    logic        scan_last;
    logic        lcdc_unused;

    assign lcdc_unused = ^{LCDC[7:3], LCDC[0]};

    sprite_match u_match (
        .ly   (ly_r),
        .y    (y_r),
        .tall (tall_r),
        .hit  (hit),
        .row  (row)
    );

    // cnt_r=k means the byte read at address k-1 is on oam_dout this cycle
    assign byte_idx   = cnt_r - 8'd1;
    assign capture_en = (state_r == SCAN) && (cnt_r >= 8'd1) && (cnt_r <= 8'(SCAN_BYTES));
    assign scan_last  = (state_r == SCAN) && (cnt_r == LAST_CNT);

    always_comb begin
        state_nx = state_r;
        if (start) begin
            state_nx = SCAN;
        end else begin
            case (state_r)
                SCAN:    if (scan_last) state_nx = DONE;
                default: state_nx = state_r;
            endcase
        end
    end

    always_comb begin
        busy     = (state_r == SCAN);
        done_out = scan_last && !start;
        oam_a    = OAM_BASE;
        if (state_r == SCAN && cnt_r < 8'(SCAN_BYTES)) begin
            oam_a = OAM_BASE + {8'h00, cnt_r};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            ly_r    <= '0;
            tall_r  <= 1'b0;
            en_r    <= 1'b0;
            y_r     <= '0;
            x_r     <= '0;
            tile_r  <= '0;
            queue_r <= '0;
            count_r <= '0;
        end else if (start) begin
            cnt_r   <= '0;
            ly_r    <= LY;
            tall_r  <= LCDC[2];
            en_r    <= LCDC[1];
            queue_r <= '0;
            count_r <= '0;
        end else if (state_r == SCAN) begin
            cnt_r <= cnt_r + 8'd1;
            if (capture_en) begin
                case (byte_idx[1:0])
                    2'd0: y_r    <= oam_dout;
                    2'd1: x_r    <= oam_dout;
                    2'd2: tile_r <= oam_dout;
                    default: begin
                        // flags byte completes the entry; Y has been held since byte 0
                        if (en_r && hit && count_r < 4'(MAX_SPRITES)) begin
                            queue_r[count_r] <= make_slot(byte_idx[7:2], row, y_r, x_r, tile_r, oam_dout);
                            count_r          <= count_r + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign sprite_queue = queue_r;
    assign sprite_count = count_r;
    assign state_dbg    = state_r;

endmodule

// File: tb/tb_mode_2_fsm.sv
// Bench for mode_2_fsm: OAM memory model, spec-level selection model, timing and reset checks.
module tb_mode_2_fsm;
    import ppu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        LCDC = 8'h00;
    logic [7:0]        LY = 8'h00;
    logic [7:0]        oam_dout;
    logic              done_out;
    logic              busy;
    logic [15:0]       oam_a;
    logic [9:0][47:0]  sprite_queue;
    logic [3:0]        sprite_count;
    state_t            state_dbg;

    logic [7:0]        oam [0:255];
    logic [47:0]       exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                n;

    mode_2_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .LCDC         (LCDC),
        .LY           (LY),
        .oam_dout     (oam_dout),
        .done_out     (done_out),
        .busy         (busy),
        .oam_a        (oam_a),
        .sprite_queue (sprite_queue),
        .sprite_count (sprite_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) oam_dout <= oam[oam_a[7:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int e, input int y, input int x);
        oam[4*e]     = 8'(y);
        oam[4*e + 1] = 8'(x);
        oam[4*e + 2] = 8'($urandom);
        oam[4*e + 3] = 8'($urandom);
    endtask

    // Selection straight from the line-coverage rule, first-come in OAM order, capped at 10
    task automatic build_expected(input logic [7:0] ly, input logic [7:0] lcdc, output int cnt);
        int h, line, y;
        exp_q.delete();
        cnt  = 0;
        h    = lcdc[2] ? 16 : 8;
        line = int'(ly) + 16;
        for (int e = 0; e < 40; e++) begin
            y = int'(oam[4*e]);
            if (lcdc[1] && line >= y && line < y + h && cnt < 10) begin
                exp_q.push_back({1'b1, 1'b0, 6'(e), 8'(line - y),
                                 oam[4*e], oam[4*e + 1], oam[4*e + 2], oam[4*e + 3]});
                cnt++;
            end
        end
        while (exp_q.size() < 10) exp_q.push_back(48'h0);
    endtask

    task automatic check_results(input string tag, input int cnt);
        logic [47:0] e;
        check({tag, "_count"}, sprite_count, cnt);
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_slot%0d", tag, i), sprite_queue[i], e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_oam_a"}, oam_a, 16'hFE00);
        check({tag, "_count"}, sprite_count, 0);
        check({tag, "_queue"}, |sprite_queue, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    task automatic run_scan(input string tag, input logic [7:0] ly, input logic [7:0] lcdc,
                            input int restart_at, output int cnt);
        int cyc, s, k, done_cnt, done_cyc, bad_oam, bad_busy, exp_done;
        logic [15:0] exp_oam;
        logic        exp_busy;
        build_expected(ly, lcdc, cnt);
        @(negedge clk);
        LY = ly; LCDC = lcdc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; s = 0; done_cnt = 0; done_cyc = -1; bad_oam = 0; bad_busy = 0;
        exp_done = (restart_at > 0 ? restart_at : 0) + 162;
        while (cyc <= exp_done + 4) begin
            k        = cyc - s;
            exp_oam  = (k >= 1 && k <= 160) ? 16'(16'hFE00 + k - 1) : 16'hFE00;
            exp_busy = (k >= 1 && k <= 162);
            if (oam_a !== exp_oam) bad_oam++;
            if (busy !== exp_busy) bad_busy++;
            if (done_out === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (k == 20) begin
                LY = 8'($urandom); LCDC = 8'($urandom);
            end
            if (cyc == restart_at) begin
                LY = ly; LCDC = lcdc; start = 1'b1;
            end
            @(negedge clk);
            if (start) begin
                start = 1'b0;
                s = cyc;
            end
            cyc++;
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_oam_a_seq"}, bad_oam, 0);
        check({tag, "_busy_seq"}, bad_busy, 0);
        check_results(tag, cnt);
        repeat (4) begin
            LY = 8'($urandom); LCDC = 8'($urandom);
            @(negedge clk);
        end
        check({tag, "_hold_count"}, sprite_count, cnt);
        check({tag, "_hold_state"}, state_dbg, DONE);
    endtask

    initial begin
        int bad, ly_r;
        for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || done_out !== 1'b0) bad++;
        end
        check("idle_after_reset", bad, 0);

        // three visible sprites at indices 0, 5, 39
        for (int e = 0; e < 40; e++) set_entry(e, 0, $urandom_range(0, 255));
        set_entry(0, 16, 8); set_entry(5, 16, 40); set_entry(39, 16, 100);
        run_scan("three", 8'd0, 8'h02, 0, n);
        check("three_cnt_const", sprite_count, 3);
        check("three_idx2", sprite_queue[2][45:40], 39);
        check("three_row1", sprite_queue[1][39:32], 0);

        // overflow: every entry matches
        for (int e = 0; e < 40; e++) set_entry(e, 20, e);
        run_scan("overflow", 8'd10, 8'h06, 0, n);
        check("overflow_cnt_const", sprite_count, 10);
        check("overflow_slot9_valid", sprite_queue[9][47], 1);
        check("overflow_slot9_idx", sprite_queue[9][45:40], 9);
        check("overflow_slot9_row", sprite_queue[9][39:32], 6);

        // height boundary
        for (int e = 0; e < 40; e++) set_entry(e, 0, 50);
        set_entry(0, 16, 50);
        run_scan("h8", 8'd8, 8'h02, 0, n);
        check("h8_cnt_const", sprite_count, 0);
        run_scan("h16", 8'd8, 8'h06, 0, n);
        check("h16_cnt_const", sprite_count, 1);
        check("h16_row", sprite_queue[0][39:32], 8);

        // restart mid-scan, then disabled sprites
        for (int e = 0; e < 40; e++) set_entry(e, $urandom_range(60, 90), $urandom_range(0, 255));
        run_scan("restart", 8'd60, 8'h06, 50, n);
        run_scan("disabled", 8'd60, 8'h04, 0, n);
        check("disabled_cnt_const", sprite_count, 0);

        // async reset mid-scan; off-screen X values still match
        for (int e = 0; e < 40; e++) set_entry(e, 0, 80);
        set_entry(3, 30, 0); set_entry(17, 32, 200);
        @(negedge clk);
        LY = 8'd20; LCDC = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0 || done_out !== 1'b0) bad++;
        end
        check("no_done_after_reset", bad, 0);
        run_scan("offscreen_x", 8'd20, 8'h02, 0, n);
        check("offscreen_x_cnt_const", sprite_count, 2);
        check("offscreen_x1", sprite_queue[1][23:16], 200);

        // randomized lines with entries clustered near the line
        for (int t = 0; t < 8; t++) begin
            ly_r = $urandom_range(0, 153);
            for (int e = 0; e < 40; e++)
                set_entry(e, $urandom_range(ly_r > 8 ? ly_r - 8 : 0, ly_r + 24), $urandom_range(0, 255));
            LCDC = 8'($urandom);
            LCDC[1] = ($urandom_range(0, 3) != 0);
            run_scan($sformatf("rand%0d", t), 8'(ly_r), LCDC, ($urandom_range(0, 2) == 0) ? $urandom_range(2, 150) : 0, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_2_fsm.md
MODE_2_FSM -- requirements
Module: mode_2_fsm

Interface
REQ-001 Parameter: MAX_SPRITES, 10, maximum sprites selected per line.
REQ-002 Parameter: OAM_ENTRIES, 40, OAM entries scanned per line.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: rst  in  1  reset, asynchronous and active-low.
REQ-005 Port: start  in  1  one-cycle pulse that begins the OAM scan for the current line.
REQ-006 Port: done_out  out  1  one-cycle pulse when the scan is complete.
REQ-007 Port: busy  out  1  high while the scan is in progress.
REQ-008 Port: oam_a  out  16  OAM read address, 0xFE00-0xFE9F.
REQ-009 Port: oam_dout  in  8  OAM read data, valid one cycle after oam_a.
REQ-010 Port: LCDC, LY  in  8 each  LCD control register and current line.
REQ-011 Port: sprite_queue  out  [9:0][47:0]  selected sprites; slot 0 holds the lowest OAM index.
REQ-012 Port: sprite_count  out  4  number of valid slots, 0-10.

Function
REQ-013 The states SHALL be IDLE, SCAN and DONE; reset and idle state is IDLE.
REQ-014 A start pulse in any state SHALL latch LY, LCDC[2] (sprite height) and LCDC[1] (sprite enable), clear the queue and count, and enter SCAN.
REQ-015 In SCAN, oam_a SHALL step 0xFE00..0xFE9F, one address per cycle, with 0xFE00 driven on the cycle after start.
REQ-016 Each byte SHALL be captured from oam_dout on the cycle after its address is driven; bytes 0-3 of an entry are Y, X, tile and flags.
REQ-017 Sprite height SHALL be 16 when latched LCDC[2]=1, otherwise 8.
REQ-018 An entry SHALL be selected when LY+16 >= Y and LY+16 < Y+height, computed at 9-bit width with no wrap.
REQ-019 X is ignored for selection, so entries with X=0 or X>=168 still consume a slot.
REQ-020 A selected entry SHALL be committed to slot sprite_count on the cycle its flags byte is captured, and sprite_count SHALL increment on that cycle.
REQ-021 Once sprite_count=10, later matching entries SHALL be dropped, but the scan still runs all 160 addresses.
REQ-022 If latched LCDC[1]=0, no entries SHALL be committed, but scan timing is unchanged.
REQ-023 Slot format SHALL be: [47] valid; [46] 0; [45:40] OAM index; [39:32] row = LY+16-Y, not flipped; [31:24] Y; [23:16] X; [15:8] tile; [7:0] flags.
REQ-024 Unused slots SHALL be all zeros.
REQ-025 done_out SHALL pulse exactly 162 cycles after start (cycle 0 is start), and the state SHALL then move to DONE.
REQ-026 After done_out, sprite_queue and sprite_count SHALL stay stable until the next start.
REQ-027 busy SHALL be high from the cycle after start through the done_out cycle inclusive.
REQ-028 In IDLE and DONE, oam_a SHALL hold 0xFE00.
REQ-029 A start pulse during SCAN SHALL abort the scan and restart it from 0xFE00 with no done_out from the aborted scan.
REQ-030 Changes to LY or LCDC during SCAN SHALL have no effect.

Reset
REQ-031 While rst=0, asynchronously: state=IDLE, done_out=0, busy=0, oam_a=0xFE00, sprite_count=0, all queue slots=0.
REQ-032 When rst is deasserted, the block SHALL wait for start and SHALL NOT scan on its own.

Structure
REQ-033 A shared package (ppu_pkg) SHALL hold MAX_SPRITES, OAM_ENTRIES, the OAM base 0xFE00, the slot field offsets and the state enum.
REQ-034 A sub-module sprite_match SHALL hold the combinational Y-range compare and row computation.
REQ-035 The block's sprite_queue SHALL connect directly to mode_3_fsm's sprite_queue input.

Verification
REQ-036 Three sprites visible: LY=0, 8x8 mode, entries 0,5,39 with Y=16 and others Y=0 -> count=3; slots 0-2 show index 0,5,39 with row=0; done_out at cycle 162.
REQ-037 Overflow: all 40 entries Y=20, LY=10, LCDC[2]=1 -> count=10; slots hold indices 0-9 with row=6; slot 9 valid.
REQ-038 Height boundary: Y=16, LY=8 -> rejected in 8x8 mode; accepted in 8x16 mode with row=8.
REQ-039 Restart and disable: start again at cycle 50 -> a single done_out at cycle 212 after the first start. LCDC[1]=0 -> count=0 and timing is unchanged.
REQ-040 Async reset at cycle 80 of a scan -> all outputs reach reset values immediately and there is no done_out; X=0 and X=200 entries in range are still selected.
